// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Groups the signals that run between the fetch stage and its neighbours.
//   - Instruction memory: pc_out (address out), instr_in (combinational data in).
//   - Execute:            redirect_valid / redirect_pc (PC change request).
//   - Decode:             fetch_valid / fetch_ready handshake carrying
//                         fetch_instr, fetch_pc, fetch_misalign, fetch_bad_pc.
//   - Debug:              dbg_state (0 = RUN, 1 = HALT).
//
// Handshake: a head entry transfers to decode on every rising clock edge where
//   fetch_valid and fetch_ready are both 1. fetch_valid never depends on
//   fetch_ready. While fetch_valid is 1 and fetch_ready is 0, the payload holds
//   unless a redirect or reset flushes the queue.
//
// Modports
//   master : the fetch unit side.
//   slave  : the environment side (instruction memory, execute, decode).
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_misalign;
  logic [31:0] fetch_bad_pc;
  logic        dbg_state;

  modport master (
    output pc_out,
    input  instr_in,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_valid,
    input  fetch_ready,
    output fetch_instr,
    output fetch_pc,
    output fetch_misalign,
    output fetch_bad_pc,
    output dbg_state
  );

  modport slave (
    input  pc_out,
    output instr_in,
    output redirect_valid,
    output redirect_pc,
    input  fetch_valid,
    output fetch_ready,
    input  fetch_instr,
    input  fetch_pc,
    input  fetch_misalign,
    input  fetch_bad_pc,
    input  dbg_state
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Front-end fetch stage of the single-cycle RV32 core.
//   - Owns the program counter and drives it to the combinational imem.
//   - Captures {pc, instr} pairs into a QUEUE_DEPTH-entry prefetch queue.
//   - Presents the queue head to decode over a valid/ready handshake.
//   - Redirects from execute flush the queue and reload the PC.
//
// Parameters
//   RESET_PC    : PC loaded by reset.
//   QUEUE_DEPTH : prefetch entries (power of 2, >= 2).
//
// Ports
//   clk   : clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : fetch_unit_if.master (imem, redirect, decode handshake, debug).
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN)
//   Defined   : a misaligned redirect flushes, holds the PC, enters HALT and
//               raises the sticky fetch_misalign flag with the offending target
//               on fetch_bad_pc. An aligned redirect resumes RUN.
//   Undefined : redirect targets are silently word-aligned; state stays RUN;
//               fetch_misalign and fetch_bad_pc are constant 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int                PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [31:0]       NOP     = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;

  // Queue storage is not reset: count_q alone decides which slots are live.
  logic [31:0]        mem_pc_q    [QUEUE_DEPTH];
  logic [31:0]        mem_instr_q [QUEUE_DEPTH];

`ifdef MISALIGN_TRAP_EN
  logic               misalign_q, misalign_d;
  logic [31:0]        bad_pc_q, bad_pc_d;
`endif

  // ---------------------------------------------------------------------------
  // Handshake terms
  // ---------------------------------------------------------------------------
  logic        head_valid;
  logic        pop;
  logic        push;
  logic [31:0] redirect_target;

  assign head_valid      = (count_q != '0) && (state_q == RUN);
  assign pop             = head_valid && bus.fetch_ready;
  // A full queue still accepts a new entry when the head leaves this cycle.
  assign push            = (state_q == RUN) && !bus.redirect_valid &&
                           ((count_q < DEPTH_C) || pop);
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
    bad_pc_d   = bad_pc_q;
`endif

    if (bus.redirect_valid) begin
      // Any same-cycle pop has already been consumed by decode; the flush
      // simply discards everything that remains.
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
`ifdef MISALIGN_TRAP_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
        bad_pc_d   = bus.redirect_pc;
      end else begin
        state_d    = RUN;
        misalign_d = 1'b0;
        pc_d       = redirect_target;
      end
`else
      pc_d = redirect_target;
`endif
    end else begin
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        pc_d   = pc_q + 32'd4;  // modulo 2^32: FFFF_FFFC wraps to 0
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      bad_pc_q   <= 32'h0;
    end else begin
      misalign_q <= misalign_d;
      bad_pc_q   <= bad_pc_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[tail_q]    <= pc_q;
      mem_instr_q[tail_q] <= bus.instr_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decode sees only registered queue contents, never instr_in.
  // ---------------------------------------------------------------------------
  assign bus.pc_out      = pc_q;
  assign bus.fetch_valid = head_valid;
  assign bus.fetch_instr = head_valid ? mem_instr_q[head_q] : NOP;
  assign bus.fetch_pc    = head_valid ? mem_pc_q[head_q] : 32'h0;
  assign bus.dbg_state   = state_q;

`ifdef MISALIGN_TRAP_EN
  assign bus.fetch_misalign = misalign_q;
  assign bus.fetch_bad_pc   = bad_pc_q;
`else
  assign bus.fetch_misalign = 1'b0;
  assign bus.fetch_bad_pc   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed scenarios with literal expectations followed by randomized
//   ready/redirect traffic. A queue-based reference model of the fetch stage
//   is compared against the main DUT on every falling clock edge. A second
//   instance with RESET_PC = FFFF_FFF8 covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RST_PC_A = 32'h0000_0000;
  localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fetch_unit_if bus ();
  fetch_unit_if bus_b ();

  fetch_unit #(.RESET_PC(RST_PC_A), .QUEUE_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  fetch_unit #(.RESET_PC(RST_PC_B), .QUEUE_DEPTH(4)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  // Instruction memory contents: word i holds i+1.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction

  assign bus.instr_in   = imem(bus.pc_out);
  assign bus_b.instr_in = imem(bus_b.pc_out);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of {pc, instr} pairs plus the fetch PC.
  // ---------------------------------------------------------------------------
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_mis;
  logic [31:0] m_bad;

  always @(negedge clk) begin : model
    logic        m_valid;
    logic        m_pop;
    logic        m_push;
    logic [63:0] head;

    if (!rst_n) begin
      exp_q.delete();
      m_pc   = RST_PC_A;
      m_halt = 1'b0;
      m_mis  = 1'b0;
      m_bad  = 32'h0;
    end

    m_valid = (exp_q.size() != 0) && !m_halt;
    head    = m_valid ? exp_q[0] : {32'h0, NOP};

    check("pc_out",         bus.pc_out,               m_pc);
    check("fetch_valid",    32'(bus.fetch_valid),     32'(m_valid));
    check("fetch_pc",       bus.fetch_pc,             head[63:32]);
    check("fetch_instr",    bus.fetch_instr,          head[31:0]);
    check("fetch_misalign", 32'(bus.fetch_misalign),  32'(m_mis));
    check("fetch_bad_pc",   bus.fetch_bad_pc,         m_bad);

    if (rst_n) begin
      m_pop  = m_valid && bus.fetch_ready;
      m_push = !m_halt && !bus.redirect_valid && ((exp_q.size() < DEPTH) || m_pop);
      if (m_pop) void'(exp_q.pop_front());
      if (bus.redirect_valid) begin
        exp_q.delete();
`ifdef MISALIGN_TRAP_EN
        if ((bus.redirect_pc % 4) != 0) begin
          m_halt = 1'b1;
          m_mis  = 1'b1;
          m_bad  = bus.redirect_pc;
        end else begin
          m_halt = 1'b0;
          m_mis  = 1'b0;
          m_pc   = bus.redirect_pc;
        end
`else
        m_pc = bus.redirect_pc - (bus.redirect_pc % 4);
`endif
      end else if (m_push) begin
        exp_q.push_back({m_pc, imem(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] held_pc;

    rst_n                = 1'b1;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = 32'h0;
    bus.fetch_ready      = 1'b1;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = 32'h0;
    bus_b.fetch_ready    = 1'b1;
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;

    // Reset state and sequential fetch with decode always ready.
    check("rst_pc_out",      bus.pc_out,            32'h0);
    check("rst_valid",       32'(bus.fetch_valid),  32'h0);
    check("rst_instr",       bus.fetch_instr,       NOP);
    check("rst_pc_out_b",    bus_b.pc_out,          32'hFFFF_FFF8);
    step();
    check("t1_valid",        32'(bus.fetch_valid),  32'h1);
    check("t1_pc0",          bus.fetch_pc,          32'h0);
    check("t1_instr0",       bus.fetch_instr,       32'h1);
    check("wrap_pc_out_1",   bus_b.pc_out,          32'hFFFF_FFFC);
    check("wrap_fetch_pc_1", bus_b.fetch_pc,        32'hFFFF_FFF8);
    step();
    check("t1_pc1",          bus.fetch_pc,          32'h4);
    check("t1_instr1",       bus.fetch_instr,       32'h2);
    check("wrap_pc_out_2",   bus_b.pc_out,          32'h0);
    step();
    check("t1_pc2",          bus.fetch_pc,          32'h8);
    check("t1_instr2",       bus.fetch_instr,       32'h3);
    check("wrap_fetch_pc_3", bus_b.fetch_pc,        32'h0);

    // Decode stalled: queue fills and the PC holds.
    bus.fetch_ready = 1'b0;
    do_reset();
    step(5);
    check("t2_pc_hold",      bus.pc_out,            32'h8);
    check("t2_head_pc",      bus.fetch_pc,          32'h0);
    bus.fetch_ready = 1'b1;
    step();
    check("t2_rel_pc4",      bus.fetch_pc,          32'h4);
    step();
    check("t2_rel_pc8",      bus.fetch_pc,          32'h8);
    step();
    check("t2_rel_pc12",     bus.fetch_pc,          32'hC);

    // Redirect while full and popping.
    bus.fetch_ready = 1'b0;
    step(3);
    check("t3_full_valid",   32'(bus.fetch_valid),  32'h1);
    bus.fetch_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    check("t3_flush_valid",  32'(bus.fetch_valid),  32'h0);
    check("t3_pc_out",       bus.pc_out,            32'h40);
    step();
    check("t3_target_pc",    bus.fetch_pc,          32'h40);
    check("t3_target_instr", bus.fetch_instr,       32'h11);

    // Asynchronous reset between clock edges.
    step(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_valid",  32'(bus.fetch_valid),  32'h0);
    check("t5_async_pc",     bus.pc_out,            RST_PC_A);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);

    // Misaligned redirect.
    held_pc            = bus.pc_out;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h42;
    step();
    bus.redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    check("t6_misalign",     32'(bus.fetch_misalign), 32'h1);
    check("t6_bad_pc",       bus.fetch_bad_pc,        32'h42);
    check("t6_pc_hold",      bus.pc_out,              held_pc);
    step(2);
    check("t6_halt_valid",   32'(bus.fetch_valid),    32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    step();
    bus.redirect_valid = 1'b0;
    check("t6_clear",        32'(bus.fetch_misalign), 32'h0);
    step();
    check("t6_resume_pc",    bus.fetch_pc,            32'h80);
`else
    check("t6_pc_aligned",   bus.pc_out,              32'h40);
    check("t6_pc_moved",     32'(bus.pc_out != held_pc), 32'(held_pc != 32'h40));
    step();
    check("t6_fetch_pc",     bus.fetch_pc,            32'h40);
    check("t6_no_flag",      32'(bus.fetch_misalign), 32'h0);
`endif

    // Randomized ready / redirect traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.fetch_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0)
        bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        bus.redirect_pc = 32'($urandom_range(0, 1023));
      step();
    end
    bus.redirect_valid = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
